// File: rtl/pulse_arb_pkg.sv
// -----------------------------------------------------------------------------
// pulse_arb_pkg
// Shared definitions for the two-requester pulse arbiter:
//   - arb_state_e      : FSM state codes (IDLE=0, GNT_A=1, GNT_B=2, GAP=3)
//   - HOLD_MAX_DEFAULT : default maximum consecutive grant cycles
//   - arbitrate()      : the decision made in IDLE and GAP
// Optional feature macro used by the arbiter: PULSE_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package pulse_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GNT_A = 3'd1,
        ST_GNT_B = 3'd2,
        ST_GAP   = 3'd3
    } arb_state_e;

    localparam int HOLD_MAX_DEFAULT = 8;

    // Decision taken from IDLE or GAP. last_b=1 means B held the most recent
    // grant, so under contention A wins; otherwise B wins.
    function automatic arb_state_e arbitrate(input logic req_a,
                                             input logic req_b,
                                             input logic last_b);
        arb_state_e nxt;
        if (req_a && req_b) begin
            nxt = last_b ? ST_GNT_A : ST_GNT_B;
        end else if (req_a) begin
            nxt = ST_GNT_A;
        end else if (req_b) begin
            nxt = ST_GNT_B;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
// Counts consecutive grant cycles for the forced-release feature. Only built
// when PULSE_ARB_TIMEOUT_EN is defined; the default build carries no counter.
// Ports:
//   clk       in  : clock, rising edge
//   reset     in  : asynchronous active-high reset (count -> 0)
//   clear_i   in  : synchronous clear, has priority over en_i
//   en_i      in  : increment one step, saturating at LIMIT
//   reached_o out : high on the grant cycle that is the LIMIT-th one, i.e.
//                   the current count is already LIMIT-1 or more
// Parameters: LIMIT (2..15), CNT_W (LIMIT must fit in CNT_W bits)
// -----------------------------------------------------------------------------
`ifdef PULSE_ARB_TIMEOUT_EN
module hold_counter #(
    parameter int LIMIT = 8,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic reached_o
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins, otherwise saturating increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT_C)) begin
            count_d = count_q + ONE_C;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The count starts at 0 on the first grant cycle, so reaching LIMIT-1
    // marks the LIMIT-th cycle; releasing there yields exactly LIMIT grants.
    assign reached_o = (count_q >= LAST_C);

endmodule
`endif

// File: rtl/pulse_arbiter.sv
// -----------------------------------------------------------------------------
// pulse_arbiter
// Two-requester arbiter with alternating priority under contention and a
// one-cycle GAP after every grant.
// Optional feature: define PULSE_ARB_TIMEOUT_EN to force release of a grant
// after HOLD_MAX consecutive cycles (timeout pulses during that GAP cycle).
// Without it grants are held indefinitely and timeout is constant 0.
// Ports:
//   clk     in      : clock, rising edge
//   reset   in      : asynchronous active-high reset
//   req_a   in      : level request from A, held until served
//   req_b   in      : level request from B, held until served
//   gnt_a   out     : registered grant to A
//   gnt_b   out     : registered grant to B
//   busy    out     : registered, gnt_a | gnt_b
//   timeout out     : registered one-cycle pulse on forced release
//   state   out [3] : current FSM state code
// -----------------------------------------------------------------------------
module pulse_arbiter
    import pulse_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_a,
    input  logic       req_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       busy,
    output logic       timeout,
    output logic [2:0] state
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_b_q;      // 1: B was granted last, 0: A was granted last
    logic       last_b_d;
    logic       gnt_a_q;
    logic       gnt_b_q;
    logic       busy_q;

`ifdef PULSE_ARB_TIMEOUT_EN
    logic       timeout_q;
    logic       force_release_s;
    logic       hold_reached_s;
    logic       granting_s;

    assign granting_s = (state_q == ST_GNT_A) || (state_q == ST_GNT_B);

    // Held clear outside grant states, so every entry into a grant starts at 0.
    hold_counter #(
        .LIMIT (HOLD_MAX),
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (!granting_s),
        .en_i      (granting_s),
        .reached_o (hold_reached_s)
    );
`endif

    // Next-state and last-granted decision.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
`ifdef PULSE_ARB_TIMEOUT_EN
        force_release_s = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_GAP: begin
                state_d = arbitrate(req_a, req_b, last_b_q);
            end
            ST_GNT_A: begin
                if (!req_a) begin
                    state_d = ST_GAP;
`ifdef PULSE_ARB_TIMEOUT_EN
                end else if (hold_reached_s) begin
                    state_d         = ST_GAP;
                    force_release_s = 1'b1;
`endif
                end else begin
                    state_d = ST_GNT_A;
                end
            end
            ST_GNT_B: begin
                if (!req_b) begin
                    state_d = ST_GAP;
`ifdef PULSE_ARB_TIMEOUT_EN
                end else if (hold_reached_s) begin
                    state_d         = ST_GAP;
                    force_release_s = 1'b1;
`endif
                end else begin
                    state_d = ST_GNT_B;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Grant states are only entered from IDLE/GAP, so any move into one
        // is a fresh grant and records the winner.
        if ((state_d == ST_GNT_A) && (state_q != ST_GNT_A)) begin
            last_b_d = 1'b0;
        end else if ((state_d == ST_GNT_B) && (state_q != ST_GNT_B)) begin
            last_b_d = 1'b1;
        end else begin
            last_b_d = last_b_q;
        end
    end

    // State and registered outputs; outputs are decoded from the next state so
    // they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_b_q  <= 1'b1;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef PULSE_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            gnt_a_q   <= (state_d == ST_GNT_A);
            gnt_b_q   <= (state_d == ST_GNT_B);
            busy_q    <= (state_d == ST_GNT_A) || (state_d == ST_GNT_B);
`ifdef PULSE_ARB_TIMEOUT_EN
            timeout_q <= force_release_s;
`endif
        end
    end

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign busy  = busy_q;
    assign state = state_q;
`ifdef PULSE_ARB_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/pulse_arbiter.md
PULSE_ARBITER -- requirements
Module: pulse_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 8, meaning maximum consecutive grant cycles before forced release (range 2..15).
REQ-002 SHALL have parameter CNT_W, default 4, meaning hold-counter width; HOLD_MAX SHALL fit in CNT_W bits.
REQ-003 SHALL have port clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_a  input  1  request from requester A, level, held until served.
REQ-006 SHALL have port req_b  input  1  request from requester B, level, held until served.
REQ-007 SHALL have port gnt_a  output  1  registered grant to A.
REQ-008 SHALL have port gnt_b  output  1  registered grant to B.
REQ-009 SHALL have port busy  output  1  registered, equals gnt_a OR gnt_b.
REQ-010 SHALL have port timeout  output  1  registered one-cycle pulse on forced release.
REQ-011 SHALL have port state  output  3  current FSM state code, for bench observation.

Function
REQ-012 SHALL implement FSM states IDLE=3'd0, GNT_A=3'd1, GNT_B=3'd2, GAP=3'd3; codes 4..7 SHALL return to IDLE on the next edge.
REQ-013 SHALL keep gnt_a and gnt_b mutually exclusive in every cycle; gnt_a=1 only in GNT_A, gnt_b=1 only in GNT_B.
REQ-014 SHALL take exactly one cycle from a request sampled high in IDLE/GAP to the corresponding grant being visible.
REQ-015 SHALL decide in IDLE and GAP identically: only one request -> grant it; both -> grant the requester not held in register last; none -> IDLE.
REQ-016 SHALL update last to the granted requester on every entry to GNT_A or GNT_B.
REQ-017 SHALL hold GNT_x while req_x is high; req_x sampled low -> GAP for exactly one cycle with no grant.
REQ-018 SHALL not preempt a grant because the other requester asserts; the other waits for GAP.
REQ-019 SHALL clear the hold counter on every entry to GNT_A/GNT_B and increment it each grant cycle, saturating at HOLD_MAX.
REQ-020 SHALL treat the counter as width CNT_W unsigned; no wrap-around SHALL occur.
REQ-021 SHALL leave the GNT_x state unaffected by simultaneous req_a/req_b edges other than per REQ-017.

Reset
REQ-022 SHALL, while reset is high, force state=IDLE, gnt_a=0, gnt_b=0, busy=0, timeout=0, counter=0, last=B, regardless of clk.
REQ-023 SHALL, on reset asserted mid-grant, drop the grant immediately (asynchronously) and resume at IDLE; first post-reset contention SHALL grant A.

Configuration
REQ-024 SHALL use macro PULSE_ARB_TIMEOUT_EN to compile the forced-release feature in or out.
REQ-025 SHALL, with PULSE_ARB_TIMEOUT_EN defined, leave GNT_x for GAP when the counter reaches HOLD_MAX with req_x still high, pulse timeout for the GAP cycle, and apply REQ-015 in GAP (other requester wins if requesting, else x is regranted).
REQ-026 SHALL, without PULSE_ARB_TIMEOUT_EN, hold grants indefinitely, tie timeout to 0 and omit the counter logic.

Structure
REQ-027 SHALL place the state codes and the default HOLD_MAX in shared package pulse_arb_pkg.
REQ-028 SHALL implement the hold counter as sub-module hold_counter (clear, enable, saturate-at-limit, reached flag); no other sub-modules.

Verification
REQ-029 Bench SHALL use a 20 ns clock period, reset high 15 ns then low, all stimulus changing away from rising edges.
REQ-030 Reset then req_a high 3 cycles -> gnt_a high 3 cycles starting 1 cycle later, then state 3 for 1 cycle, then state 0.
REQ-031 req_a and req_b rise together after reset -> gnt_a first; on req_a drop -> one GAP cycle then gnt_b; next joint contention -> gnt_a (alternation).
REQ-032 During gnt_b, req_a asserts -> gnt_b not preempted; gnt_a appears exactly 2 cycles after req_b sampled low.
REQ-033 With PULSE_ARB_TIMEOUT_EN and HOLD_MAX=8, req_a held 20 cycles, req_b low -> gnt_a 8 cycles, timeout pulse with GAP, gnt_a regranted; with req_b high -> gnt_b after GAP.
REQ-034 Reset pulsed high mid-gnt_a -> gnt_a, busy, state go 0 before the next clock edge; gnt_a=1 at no cycle where gnt_b=1 across all scenarios.
